mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised successor of the MEM pipeline stage for the in-order core. It latches EX-stage results under the shared stall vector and accepts load data with variable latency from data SRAM, requesting a stall until the data arrives. It aligns and sign/zero-extends the loaded bytes and drives the WB bus plus a forwarding port for ID-stage bypass.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
PC_W, 32, PC width.
RF_AW, 5, register-file address width.
STALL_W, 6, stall vector width.
STAGE_IDX, 3, this stage's bit in the stall vector; STAGE_IDX+1 must be less than STALL_W.
OFS_W, $clog2(XLEN/8), width of the byte-offset field.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stall  in  STALL_W  pipeline stall vector; 1 = Stop
flush  in  1  exception/redirect flush
in_valid  in  1  EX entry valid
in_pc  in  PC_W  EX PC
in_ld_en  in  1  entry is a load
in_ld_type  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
in_addr_ofs  in  OFS_W  low address bits of the load
in_rf_we  in  1  register write enable
in_rf_waddr  in  RF_AW  destination register
in_ex_result  in  XLEN  ALU result
data_sram_rdata  in  XLEN  load response data
data_sram_rvalid  in  1  load response valid, single-cycle pulse
stallreq  out  1  load pending; freezes this stage and all earlier stages
wb_valid  out  1  WB bus valid
wb_pc  out  PC_W  PC to WB
wb_rf_we  out  1  register write enable to WB
wb_rf_waddr  out  RF_AW  destination register to WB
wb_rf_wdata  out  XLEN  write-back data
fwd_we  out  1  forwarding write enable
fwd_waddr  out  RF_AW  forwarding register address
fwd_wdata  out  XLEN  forwarding data

Behaviour:
- Entry register update, highest priority first:
  - rst: clear all fields.
  - flush: clear all fields.
  - stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0: insert a bubble (all fields 0).
  - stall[STAGE_IDX]=0: capture the in_* inputs.
  - Otherwise: hold.
- Load FSM. Reset state is IDLE.
  - IDLE: on capturing a valid load, go to WAIT.
  - WAIT with rvalid and the stage advancing: go to WAIT if the newly captured entry is a valid load, else IDLE.
  - WAIT with rvalid and the stage held: latch rdata into rbuf and go to HAVE.
  - WAIT without rvalid: stay in WAIT.
  - HAVE: when the stage advances, go to WAIT if the new entry is a valid load, else IDLE.
- stallreq = (state==WAIT) && !data_sram_rvalid. It is combinational and zero-latency, so a response in the same cycle releases the stall.
- Entry ready:
  - Non-load valid entries are ready immediately.
  - Loads are ready in WAIT with rvalid, or in HAVE.
  - wb_valid = entry valid && ready.
  - wb_rf_we = wb_valid && rf_we.
  - wb_pc and wb_rf_waddr come straight from the entry register.
- Load data source is rbuf in HAVE, else data_sram_rdata.
  - Byte: lane = in_addr_ofs*8.
  - Half: lane = in_addr_ofs[OFS_W-1:1]*16.
  - Word (XLEN=64 only): lane = in_addr_ofs[OFS_W-1]*32.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
  - LD returns the full XLEN value.
  - With XLEN=32, LD and LWU both return the full word.
  - Misaligned offsets are not checked; lane selection ignores the low bits.
- wb_rf_wdata is the aligned load data when ld_en, else ex_result.
- Forwarding outputs mirror the WB outputs (fwd_we = wb_rf_we), so no forwarding happens while a load is not ready.
- Flush while in WAIT:
  - Set drop_pending.
  - The next rvalid is discarded: no state change, and it clears drop_pending.
  - If a new load is captured before that stale rvalid, that rvalid is still dropped and the new load waits for the following one.
- rvalid in IDLE or HAVE with drop_pending=0 is spurious and ignored.
- Reset values: all outputs 0, state IDLE, rbuf 0, drop_pending 0. Reset mid-WAIT abandons the load and does not set drop_pending; the external SRAM is reset too.

Test Plan:
- Non-load: capture ALU entry (pc=0xBFC00000, rf_we=1, waddr=5, ex_result=0x1234) with stall=0 -> next cycle wb_valid=1, wb_rf_wdata=0x1234, stallreq=0.
- Load latency 3: LB at ofs 2, rdata=0x00800000, rvalid 3 cycles after capture -> stallreq=1 for 2 cycles, then 0; wb_rf_wdata=0xFFFFFF80 in the rvalid cycle; LBU variant yields 0x00000080.
- Downstream hold: rvalid with LH ofs 2, rdata=0x8001_0000, while stall[4]=1 -> HAVE; rdata changes after that; on release wb_rf_wdata=0xFFFF8001.
- Bubble: stall[3]=1, stall[4]=0 -> following cycle wb_valid=0, wb_rf_we=0, fwd_we=0.
- Flush in WAIT, new LW captured, two rvalid pulses with 0xDEAD and 0xBEEF -> first dropped; wb_rf_wdata=0x0000BEEF.
- XLEN=64: LWU ofs 4, rdata=0xFFFFFFFF_00000000 -> wb_rf_wdata=0x00000000_FFFFFFFF; LW -> 0xFFFFFFFF_FFFFFFFF.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with variable-latency load completion: latches EX results,
// stalls until load data arrives, aligns/extends it and drives WB plus ID forwarding.
module mem_stage_lsu #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int RF_AW     = 5,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int OFS_W     = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_ld_en,
  input  logic [2:0]         in_ld_type,
  input  logic [OFS_W-1:0]   in_addr_ofs,
  input  logic               in_rf_we,
  input  logic [RF_AW-1:0]   in_rf_waddr,
  input  logic [XLEN-1:0]    in_ex_result,
  input  logic [XLEN-1:0]    data_sram_rdata,
  input  logic               data_sram_rvalid,
  output logic               stallreq,
  output logic               wb_valid,
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_rf_we,
  output logic [RF_AW-1:0]   wb_rf_waddr,
  output logic [XLEN-1:0]    wb_rf_wdata,
  output logic               fwd_we,
  output logic [RF_AW-1:0]   fwd_waddr,
  output logic [XLEN-1:0]    fwd_wdata
);

  localparam int NB = XLEN / 8;
  localparam int NH = XLEN / 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HAVE = 2'd2
  } state_t;

  logic               valid_reg;
  logic [PC_W-1:0]    pc_reg;
  logic               ld_en_reg;
  logic [2:0]         ld_type_reg;
  logic [OFS_W-1:0]   ofs_reg;
  logic               rf_we_reg;
  logic [RF_AW-1:0]   rf_waddr_reg;
  logic [XLEN-1:0]    ex_result_reg;

  state_t             state_reg, state_next;
  logic [XLEN-1:0]    rbuf_reg, rbuf_next;
  logic               drop_reg, drop_next;

  logic               advance;
  logic               bubble;
  logic               rsp_ok;
  logic               new_load;
  logic               ready;

  assign advance  = ~stall[STAGE_IDX];
  assign bubble   = stall[STAGE_IDX] & ~stall[STAGE_IDX+1];
  // A response owed to a flushed load must never complete the current entry.
  assign rsp_ok   = data_sram_rvalid & ~drop_reg;
  assign new_load = advance & ~flush & in_valid & in_ld_en;

  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      valid_reg     <= 1'b0;
      pc_reg        <= '0;
      ld_en_reg     <= 1'b0;
      ld_type_reg   <= '0;
      ofs_reg       <= '0;
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= '0;
      ex_result_reg <= '0;
    end else if (advance) begin
      valid_reg     <= in_valid;
      pc_reg        <= in_pc;
      ld_en_reg     <= in_ld_en;
      ld_type_reg   <= in_ld_type;
      ofs_reg       <= in_addr_ofs;
      rf_we_reg     <= in_rf_we;
      rf_waddr_reg  <= in_rf_waddr;
      ex_result_reg <= in_ex_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      rbuf_reg  <= '0;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      rbuf_reg  <= rbuf_next;
      drop_reg  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rbuf_next  = rbuf_reg;
    drop_next  = drop_reg;
    if (data_sram_rvalid && drop_reg) begin
      drop_next = 1'b0;
    end
    case (state_reg)
      ST_IDLE: begin
        if (new_load) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (rsp_ok) begin
          if (advance) begin
            state_next = new_load ? ST_WAIT : ST_IDLE;
          end else begin
            state_next = ST_HAVE;
            rbuf_next  = data_sram_rdata;
          end
        end
      end
      ST_HAVE: begin
        if (advance) state_next = new_load ? ST_WAIT : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A flushed load still has its response in flight; remember to swallow it.
    if (flush) begin
      state_next = ST_IDLE;
      if (state_reg == ST_WAIT && !rsp_ok) drop_next = 1'b1;
    end
  end

  assign stallreq = (state_reg == ST_WAIT) & ~rsp_ok;
  assign ready    = valid_reg & (~ld_en_reg | (state_reg == ST_HAVE) |
                                 ((state_reg == ST_WAIT) & rsp_ok));

  logic [XLEN-1:0] ld_src;
  logic [7:0]      byte_lane [NB];
  logic [15:0]     half_lane [NH];
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] word_s;
  logic [XLEN-1:0] word_u;
  logic [XLEN-1:0] ld_data;

  assign ld_src = (state_reg == ST_HAVE) ? rbuf_reg : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      assign byte_lane[gi] = ld_src[gi*8 +: 8];
    end
    for (gi = 0; gi < NH; gi++) begin : g_half
      assign half_lane[gi] = ld_src[gi*16 +: 16];
    end
    if (XLEN == 64) begin : g_word64
      logic [31:0] word_sel;
      assign word_sel = ofs_reg[OFS_W-1] ? ld_src[XLEN-1:XLEN-32] : ld_src[31:0];
      assign word_s   = {{(XLEN-32){word_sel[31]}}, word_sel};
      assign word_u   = {{(XLEN-32){1'b0}}, word_sel};
    end else begin : g_word32
      assign word_s = ld_src;
      assign word_u = ld_src;
    end
  endgenerate

  // Low offset bits below the access size are ignored; misalignment is not flagged.
  assign byte_sel = byte_lane[ofs_reg];
  assign half_sel = half_lane[ofs_reg[OFS_W-1:1]];

  always_comb begin
    ld_data = ld_src;
    case (ld_type_reg)
      3'b000:  ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b010:  ld_data = word_s;
      3'b011:  ld_data = ld_src;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, half_sel};
      3'b110:  ld_data = word_u;
      default: ld_data = ld_src;
    endcase
  end

  assign wb_valid    = ready;
  assign wb_pc       = pc_reg;
  assign wb_rf_we    = ready & rf_we_reg;
  assign wb_rf_waddr = rf_waddr_reg;
  assign wb_rf_wdata = ld_en_reg ? ld_data : ex_result_reg;

  assign fwd_we      = wb_rf_we;
  assign fwd_waddr   = wb_rf_waddr;
  assign fwd_wdata   = wb_rf_wdata;

  // Only this stage's bit and the next one matter here.
  logic unused_stall;
  assign unused_stall = ^stall;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: XLEN=32 and XLEN=64 instances share control stimulus and
// are checked every cycle against a transaction-level model with an in-order SRAM queue.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic        in_ld_en;
  logic [2:0]  in_ld_type;
  logic [2:0]  in_addr_ofs;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic [63:0] in_ex_result;
  logic [63:0] rdata;
  logic        rvalid;

  logic        s32_stallreq, s32_wb_valid, s32_wb_rf_we, s32_fwd_we;
  logic [31:0] s32_wb_pc, s32_wb_rf_wdata, s32_fwd_wdata;
  logic [4:0]  s32_wb_rf_waddr, s32_fwd_waddr;
  logic        s64_stallreq, s64_wb_valid, s64_wb_rf_we, s64_fwd_we;
  logic [31:0] s64_wb_pc;
  logic [63:0] s64_wb_rf_wdata, s64_fwd_wdata;
  logic [4:0]  s64_wb_rf_waddr, s64_fwd_waddr;

  mem_stage_lsu #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_ld_en(in_ld_en), .in_ld_type(in_ld_type),
    .in_addr_ofs(in_addr_ofs[1:0]), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_ex_result(in_ex_result[31:0]), .data_sram_rdata(rdata[31:0]),
    .data_sram_rvalid(rvalid), .stallreq(s32_stallreq), .wb_valid(s32_wb_valid),
    .wb_pc(s32_wb_pc), .wb_rf_we(s32_wb_rf_we), .wb_rf_waddr(s32_wb_rf_waddr),
    .wb_rf_wdata(s32_wb_rf_wdata), .fwd_we(s32_fwd_we), .fwd_waddr(s32_fwd_waddr),
    .fwd_wdata(s32_fwd_wdata)
  );

  mem_stage_lsu #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_ld_en(in_ld_en), .in_ld_type(in_ld_type),
    .in_addr_ofs(in_addr_ofs), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_ex_result(in_ex_result), .data_sram_rdata(rdata),
    .data_sram_rvalid(rvalid), .stallreq(s64_stallreq), .wb_valid(s64_wb_valid),
    .wb_pc(s64_wb_pc), .wb_rf_we(s64_wb_rf_we), .wb_rf_waddr(s64_wb_rf_waddr),
    .wb_rf_wdata(s64_wb_rf_wdata), .fwd_we(s64_fwd_we), .fwd_waddr(s64_fwd_waddr),
    .fwd_wdata(s64_fwd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stimulus for the next cycle
  logic        cur_flush, cur_valid, cur_ld, cur_we, cur_rvalid;
  logic [31:0] cur_pc;
  logic [2:0]  cur_type, cur_ofs;
  logic [4:0]  cur_waddr;
  logic [63:0] cur_ex, cur_rdata;
  int          cur_k;
  bit          auto_sram = 0;
  int          sram_q[$];

  // Reference model: the entry in the stage plus the status of its load data
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        ld;
    logic [2:0]  typ;
    logic [2:0]  ofs;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] ex;
  } ent_t;

  ent_t        m_e;
  bit          m_wait, m_have, m_stale;
  logic [63:0] m_buf;
  bit          e_sreq, e_rdy;

  function automatic logic [63:0] sext(input logic [63:0] v, input int n);
    if (v[n-1]) return v | (64'hFFFF_FFFF_FFFF_FFFF << n);
    return v;
  endfunction

  function automatic logic [63:0] extract(input int xl, input logic [63:0] src_in,
                                          input logic [2:0] t, input int ofs_in);
    logic [63:0] src, b, h, w, r;
    int ofs;
    src = (xl == 32) ? (src_in & 64'hFFFF_FFFF) : src_in;
    ofs = (xl == 32) ? ofs_in % 4 : ofs_in;
    b = (src >> (8 * ofs)) & 64'hFF;
    h = (src >> (16 * (ofs / 2))) & 64'hFFFF;
    w = (xl == 64) ? ((src >> (32 * (ofs / 4))) & 64'hFFFF_FFFF) : src;
    case (t)
      3'd0:    r = sext(b, 8);
      3'd1:    r = sext(h, 16);
      3'd2:    r = sext(w, 32);
      3'd4:    r = b;
      3'd5:    r = h;
      3'd6:    r = w;
      default: r = src;
    endcase
    return (xl == 32) ? (r & 64'hFFFF_FFFF) : r;
  endfunction

  task automatic check_dut(input string p, input int xl, input logic sr, input logic wv,
                           input logic [31:0] pc, input logic we, input logic [4:0] wa,
                           input logic [63:0] wd, input logic fwe, input logic [4:0] fwa,
                           input logic [63:0] fwd);
    logic [63:0] exp_wd;
    exp_wd = m_e.ld ? extract(xl, m_have ? m_buf : cur_rdata, m_e.typ, int'(m_e.ofs))
                    : ((xl == 32) ? (m_e.ex & 64'hFFFF_FFFF) : m_e.ex);
    check_eq({p, "_stallreq"},    64'(sr),  64'(e_sreq));
    check_eq({p, "_wb_valid"},    64'(wv),  64'(e_rdy));
    check_eq({p, "_wb_pc"},       64'(pc),  64'(m_e.pc));
    check_eq({p, "_wb_rf_we"},    64'(we),  64'(e_rdy && m_e.we));
    check_eq({p, "_wb_rf_waddr"}, 64'(wa),  64'(m_e.waddr));
    check_eq({p, "_wb_rf_wdata"}, wd,       exp_wd);
    check_eq({p, "_fwd_we"},      64'(fwe), 64'(e_rdy && m_e.we));
    check_eq({p, "_fwd_waddr"},   64'(fwa), 64'(m_e.waddr));
    check_eq({p, "_fwd_wdata"},   fwd,      exp_wd);
  endtask

  task automatic step();
    bit rsp, adv, bub, new_load;
    logic [5:0] sv;
    @(negedge clk);
    cyc++;
    if (auto_sram) begin
      cur_rvalid = 1'b0;
      if (sram_q.size() > 0 && sram_q[0] <= cyc) begin
        cur_rvalid = 1'b1;
        void'(sram_q.pop_front());
      end
    end
    flush = cur_flush; in_valid = cur_valid; in_pc = cur_pc; in_ld_en = cur_ld;
    in_ld_type = cur_type; in_addr_ofs = cur_ofs; in_rf_we = cur_we;
    in_rf_waddr = cur_waddr; in_ex_result = cur_ex; rvalid = cur_rvalid; rdata = cur_rdata;
    // Stall controller: a pending load freezes stages 0..4
    rsp    = cur_rvalid && !m_stale;
    e_sreq = m_wait && !rsp;
    sv     = 6'((1 << cur_k) - 1) | (e_sreq ? 6'b011111 : 6'b000000);
    stall  = sv;
    adv    = !sv[3];
    bub    = sv[3] && !sv[4];
    e_rdy  = m_e.valid && (!m_e.ld || m_have || (m_wait && rsp));
    #1;
    check_dut("x32", 32, s32_stallreq, s32_wb_valid, s32_wb_pc, s32_wb_rf_we, s32_wb_rf_waddr,
              64'(s32_wb_rf_wdata), s32_fwd_we, s32_fwd_waddr, 64'(s32_fwd_wdata));
    check_dut("x64", 64, s64_stallreq, s64_wb_valid, s64_wb_pc, s64_wb_rf_we, s64_wb_rf_waddr,
              s64_wb_rf_wdata, s64_fwd_we, s64_fwd_waddr, s64_fwd_wdata);
    if (e_rdy && adv)
      $display("TXN cyc=%0d pc=0x%08h ld=%0b type=%0d rd=%0d we=%0b d32=0x%08h d64=0x%016h",
               cyc, m_e.pc, m_e.ld, m_e.typ, m_e.waddr, m_e.we, s32_wb_rf_wdata, s64_wb_rf_wdata);
    // Advance the model to the next cycle
    new_load = adv && !cur_flush && cur_valid && cur_ld;
    if (cur_flush && m_wait && !rsp) m_stale = 1;
    else if (cur_rvalid && m_stale)  m_stale = 0;
    if (cur_flush) begin
      m_e = '0; m_wait = 0; m_have = 0;
    end else begin
      if (m_wait && rsp && !adv) begin
        m_have = 1; m_buf = cur_rdata; m_wait = 0;
      end
      if (adv) begin
        m_have = 0; m_wait = new_load;
      end
      if (bub) m_e = '0;
      else if (adv) m_e = '{cur_valid, cur_pc, cur_ld, cur_type, cur_ofs, cur_we, cur_waddr, cur_ex};
    end
    if (new_load && auto_sram) sram_q.push_back(cyc + int'($urandom_range(1, 4)));
  endtask

  task automatic set_idle();
    cur_flush = 0; cur_valid = 0; cur_ld = 0; cur_we = 0; cur_rvalid = 0;
    cur_pc = '0; cur_type = '0; cur_ofs = '0; cur_waddr = '0; cur_ex = '0; cur_rdata = '0;
    cur_k = 0;
  endtask

  task automatic set_load(input logic [2:0] t, input logic [2:0] o, input logic [4:0] rd);
    set_idle();
    cur_valid = 1; cur_ld = 1; cur_type = t; cur_ofs = o; cur_we = 1; cur_waddr = rd;
    cur_pc = 32'h8000_0000 + 32'(rd) * 4; cur_ex = 64'h0BAD_0BAD;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; flush = 0; in_valid = 0; in_ld_en = 0; rvalid = 0; stall = '0;
    in_pc = '0; in_ld_type = '0; in_addr_ofs = '0; in_rf_we = 0; in_rf_waddr = '0;
    in_ex_result = '0; rdata = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_e = '0; m_wait = 0; m_have = 0; m_stale = 0; m_buf = '0;
    sram_q.delete();
    #1;
    check_eq("rst_x32_stallreq", 64'(s32_stallreq), 64'(0));
    check_eq("rst_x32_wb_valid", 64'(s32_wb_valid), 64'(0));
    check_eq("rst_x32_wdata",    64'(s32_wb_rf_wdata), 64'(0));
    check_eq("rst_x64_wb_pc",    64'(s64_wb_pc), 64'(0));
    check_eq("rst_x64_fwd_we",   64'(s64_fwd_we), 64'(0));
  endtask

  initial begin
    rst = 1;
    set_idle();
    do_reset();

    // ALU result passes straight through
    set_idle(); cur_valid = 1; cur_pc = 32'hBFC0_0000; cur_we = 1; cur_waddr = 5; cur_ex = 64'h1234;
    step();
    set_idle(); step();
    check_eq("alu_wb_valid", 64'(s32_wb_valid), 64'(1));
    check_eq("alu_wdata",    64'(s32_wb_rf_wdata), 64'h1234);
    check_eq("alu_stallreq", 64'(s32_stallreq), 64'(0));

    // LB / LBU with response three cycles after capture
    for (int v = 0; v < 2; v++) begin
      set_load((v == 0) ? 3'd0 : 3'd4, 3'd2, 5'd7);
      step();
      set_idle(); cur_rdata = 64'h0080_0000;
      step(); check_eq("lb_stall_c1", 64'(s32_stallreq), 64'(1));
      step(); check_eq("lb_stall_c2", 64'(s32_stallreq), 64'(1));
      cur_rvalid = 1;
      step();
      check_eq("lb_stall_c3", 64'(s32_stallreq), 64'(0));
      check_eq("lb_wdata32", 64'(s32_wb_rf_wdata), (v == 0) ? 64'hFFFF_FF80 : 64'h80);
      check_eq("lb_wdata64", s64_wb_rf_wdata, (v == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
    end

    // LH answered while downstream is held, released later from the buffer
    set_load(3'd1, 3'd2, 5'd9); step();
    set_idle(); cur_rvalid = 1; cur_rdata = 64'h8001_0000; cur_k = 5; step();
    cur_rvalid = 0; cur_rdata = 64'h5A5A_5A5A_5A5A_5A5A; step();
    cur_k = 0; step();
    check_eq("hold_wb_valid", 64'(s32_wb_valid), 64'(1));
    check_eq("hold_wdata32",  64'(s32_wb_rf_wdata), 64'hFFFF_8001);

    // Bubble: stage held while the next one runs
    set_idle(); cur_valid = 1; cur_we = 1; cur_waddr = 3; cur_ex = 64'h55; step();
    set_idle(); cur_k = 4; step();
    set_idle(); step();
    check_eq("bub_wb_valid", 64'(s32_wb_valid), 64'(0));
    check_eq("bub_wb_rf_we", 64'(s32_wb_rf_we), 64'(0));
    check_eq("bub_fwd_we",   64'(s64_fwd_we), 64'(0));

    // Flush mid-load: the stale response must not complete the next load
    set_load(3'd2, 3'd0, 5'd11); step();
    set_idle(); step();
    cur_flush = 1; step();
    set_load(3'd2, 3'd0, 5'd12); step();
    set_idle(); cur_rvalid = 1; cur_rdata = 64'hDEAD; step();
    check_eq("flush_stale_stall", 64'(s32_stallreq), 64'(1));
    check_eq("flush_stale_valid", 64'(s32_wb_valid), 64'(0));
    cur_rdata = 64'hBEEF; step();
    check_eq("flush_wb_valid", 64'(s32_wb_valid), 64'(1));
    check_eq("flush_wdata",    64'(s32_wb_rf_wdata), 64'h0000_BEEF);

    // 64-bit word lanes
    set_load(3'd6, 3'd4, 5'd13); step();
    set_idle(); cur_rvalid = 1; cur_rdata = 64'hFFFF_FFFF_0000_0000; step();
    check_eq("lwu64_wdata", s64_wb_rf_wdata, 64'h0000_0000_FFFF_FFFF);
    set_load(3'd2, 3'd4, 5'd14); step();
    set_idle(); cur_rvalid = 1; cur_rdata = 64'hFFFF_FFFF_0000_0000; step();
    check_eq("lw64_wdata", s64_wb_rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    set_idle(); step();

    // Randomized traffic with an in-order SRAM of random latency
    auto_sram = 1;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      cur_valid = ($urandom_range(0, 3) != 0);
      cur_ld    = 1'($urandom_range(0, 1));
      cur_type  = 3'($urandom_range(0, 6));
      cur_ofs   = 3'($urandom_range(0, 7));
      cur_we    = 1'($urandom_range(0, 1));
      cur_waddr = 5'($urandom_range(0, 31));
      cur_pc    = $urandom;
      cur_ex    = {$urandom, $urandom};
      cur_rdata = {$urandom, $urandom};
      cur_k     = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 6));
      cur_flush = !m_stale && ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
